// File: rtl/forwarding_unit.sv
// EX-stage data-hazard forwarding selector for the 16-register pipeline.
// Picks the youngest in-flight producer of each ALU source operand, or the register file.
module forwarding_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       xm_regwrite,
  input  logic       mw_regwrite,
  input  logic       xm_memread,
  input  logic [3:0] xm_rd,
  input  logic [3:0] xm_rt,
  input  logic [3:0] mw_rd,
  input  logic [3:0] dx_rs,
  input  logic [3:0] dx_rt,
  output logic [1:0] forwarda,
  output logic [2:0] forwardb
);

  typedef enum logic [1:0] {
    SRC_RF   = 2'd0,
    SRC_MW   = 2'd1,
    SRC_XM   = 2'd2,
    SRC_LOAD = 2'd3
  } src_e;

  // A two-state flag starts at 0, so the selects read register file from time zero.
  bit armed;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  // An X on any compared input makes its condition non-true, so it falls through to SRC_RF.
  function automatic src_e pick_source(input logic [3:0] src);
    pick_source = SRC_RF;
    if (src != 4'd0) begin
      if (xm_memread && (xm_rt == src))       pick_source = SRC_LOAD;
      else if (xm_regwrite && (xm_rd == src)) pick_source = SRC_XM;
      else if (mw_regwrite && (mw_rd == src)) pick_source = SRC_MW;
    end
  endfunction

  src_e src_a;
  src_e src_b;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block
    // leaves a value unassigned, which would otherwise infer a latch.
    src_a = SRC_RF;
    src_b = SRC_RF;
    if (armed) begin
      src_a = pick_source(dx_rs);
      src_b = pick_source(dx_rt);
    end
  end

  assign forwarda = src_a;

  // Operand B's mux is one-hot, so the load source moves to bit 2.
  always_comb begin
    forwardb = 3'b000;
    case (src_b)
      SRC_MW:   forwardb = 3'b001;
      SRC_XM:   forwardb = 3'b010;
      SRC_LOAD: forwardb = 3'b100;
      default:  forwardb = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit: directed vector table, reset sequences,
// and randomized stimulus compared against a priority-list reference model.
module tb_forwarding_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       xm_regwrite, mw_regwrite, xm_memread;
  logic [3:0] xm_rd, xm_rt, mw_rd, dx_rs, dx_rt;
  logic [1:0] forwarda;
  logic [2:0] forwardb;

  int tests  = 0;
  int failed = 0;

  forwarding_unit dut (
    .clk         (clk),
    .rst         (rst),
    .xm_regwrite (xm_regwrite),
    .mw_regwrite (mw_regwrite),
    .xm_memread  (xm_memread),
    .xm_rd       (xm_rd),
    .xm_rt       (xm_rt),
    .mw_rd       (mw_rd),
    .dx_rs       (dx_rs),
    .dx_rt       (dx_rt),
    .forwarda    (forwarda),
    .forwardb    (forwardb)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       xm_regwrite;
    logic       mw_regwrite;
    logic       xm_memread;
    logic [3:0] xm_rd;
    logic [3:0] xm_rt;
    logic [3:0] mw_rd;
    logic [3:0] dx_rs;
    logic [3:0] dx_rt;
    logic [1:0] exp_a;
    logic [2:0] exp_b;
  } vec_t;

  task automatic check(input string name, input logic [1:0] exp_a, input logic [2:0] exp_b);
    tests++;
    if (forwarda !== exp_a || forwardb !== exp_b) begin
      failed++;
      $display("FAIL %s: got forwarda=%b forwardb=%b, expected forwarda=%b forwardb=%b",
               name, forwarda, forwardb, exp_a, exp_b);
    end
  endtask

  task automatic drive(input logic r, input logic xw, input logic mw, input logic ld,
                       input logic [3:0] xd, input logic [3:0] xt, input logic [3:0] md,
                       input logic [3:0] rs, input logic [3:0] rt);
    rst = r; xm_regwrite = xw; mw_regwrite = mw; xm_memread = ld;
    xm_rd = xd; xm_rt = xt; mw_rd = md; dx_rs = rs; dx_rt = rt;
  endtask

  // Inputs change while clk is low; sampling happens 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the producers from youngest to oldest; first hit wins.
  function automatic int model_source(input logic [3:0] src, input logic ld, input logic [3:0] xt,
                                      input logic xw, input logic [3:0] xd,
                                      input logic mw, input logic [3:0] md);
    logic       en  [3];
    logic [3:0] dst [3];
    int         code[3];
    en[0] = ld; dst[0] = xt; code[0] = 3;
    en[1] = xw; dst[1] = xd; code[1] = 2;
    en[2] = mw; dst[2] = md; code[2] = 1;
    if (src == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (en[i] && dst[i] == src) return code[i];
    return 0;
  endfunction

  vec_t vecs[12];

  initial begin
    int b_map[4];
    bit model_armed;
    b_map[0] = 0; b_map[1] = 1; b_map[2] = 2; b_map[3] = 4;

    //           name            rst xw mw ld xd xt md rs rt  a      b
    vecs[0]  = '{"reset_hold_1",  1, 1, 0, 0, 1, 1, 1, 1, 1, 2'b00, 3'b000};
    vecs[1]  = '{"reset_hold_2",  1, 1, 0, 0, 1, 1, 1, 1, 1, 2'b00, 3'b000};
    vecs[2]  = '{"mw_forward",    0, 0, 1, 0, 1, 1, 1, 1, 1, 2'b01, 3'b001};
    vecs[3]  = '{"load_forward",  0, 0, 0, 1, 1, 1, 1, 1, 1, 2'b11, 3'b100};
    vecs[4]  = '{"xm_over_mw",    0, 1, 1, 0, 1, 1, 1, 1, 1, 2'b10, 3'b010};
    vecs[5]  = '{"xm_rd_miss",    0, 1, 1, 0, 2, 1, 1, 1, 1, 2'b01, 3'b001};
    vecs[6]  = '{"indep_r0",      0, 1, 1, 0, 3, 1, 0, 3, 0, 2'b10, 3'b000};
    vecs[7]  = '{"load_over_all", 0, 1, 1, 1, 1, 1, 1, 1, 1, 2'b11, 3'b100};
    vecs[8]  = '{"split_a_b",     0, 1, 0, 1, 7, 5, 0, 5, 7, 2'b11, 3'b010};
    vecs[9]  = '{"all_r0",        0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000};
    vecs[10] = '{"mw_r15",        0, 0, 1, 0, 0, 0, 15, 15, 15, 2'b01, 3'b001};
    vecs[11] = '{"no_enables",    0, 0, 0, 0, 1, 1, 1, 1, 1, 2'b00, 3'b000};

    // Before any clock edge the flag is clear, whatever the inputs say.
    drive(0, 1, 1, 1, 1, 1, 1, 1, 1);
    #1;
    check("time_zero", 2'b00, 3'b000);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].xm_regwrite, vecs[i].mw_regwrite, vecs[i].xm_memread,
            vecs[i].xm_rd, vecs[i].xm_rt, vecs[i].mw_rd, vecs[i].dx_rs, vecs[i].dx_rt);
      step();
      check(vecs[i].name, vecs[i].exp_a, vecs[i].exp_b);
    end

    // Zero latency: an input change is visible without a clock edge.
    drive(0, 0, 1, 0, 0, 0, 4, 4, 4);
    #2;
    check("comb_change", 2'b01, 3'b001);

    // Mid-run reset: synchronous, so it only bites at the edge and releases one edge later.
    drive(0, 1, 0, 0, 1, 1, 1, 1, 1);
    step();
    check("midrst_before", 2'b10, 3'b010);
    rst = 1'b1;
    #1;
    check("midrst_not_yet", 2'b10, 3'b010);
    step();
    check("midrst_held", 2'b00, 3'b000);
    rst = 1'b0;
    #1;
    check("midrst_release_wait", 2'b00, 3'b000);
    step();
    check("midrst_restored", 2'b10, 3'b010);

    // Randomized: small index range so hits on every producer are frequent.
    model_armed = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int ea, eb;
      drive(($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      model_armed = !rst;
      step();
      ea = 0;
      eb = 0;
      if (model_armed) begin
        ea = model_source(dx_rs, xm_memread, xm_rt, xm_regwrite, xm_rd, mw_regwrite, mw_rd);
        eb = b_map[model_source(dx_rt, xm_memread, xm_rt, xm_regwrite, xm_rd, mw_regwrite, mw_rd)];
      end
      check($sformatf("rand_%0d", n), 2'(ea), 3'(eb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/forwarding_unit.md
# forwarding_unit

Combinational data-hazard forwarding selector for the 16-register pipelined CPU. Sits in the EX stage and compares the source registers of the instruction in ID/EX against the destinations of older instructions in EX/MEM and MEM/WB. It drives the ALU operand-A and operand-B mux selects. A one-bit armed flag, cleared by reset, forces register-file selection until the pipeline is out of reset.

## Interface
- No parameters. Register index width is fixed at 4 bits.
- clk  input  1  system clock; only the armed flag is clocked.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- xm_regwrite  input  1  EX/MEM instruction writes a register (ALU-type result).
- mw_regwrite  input  1  MEM/WB instruction writes a register.
- xm_memread  input  1  EX/MEM instruction is a load.
- xm_rd  input  4  EX/MEM destination register (ALU-type).
- xm_rt  input  4  EX/MEM load destination register.
- mw_rd  input  4  MEM/WB destination register.
- dx_rs  input  4  ID/EX source register A.
- dx_rt  input  4  ID/EX source register B.
- forwarda  output  2  operand-A select: 00 register file, 01 MEM/WB result, 10 EX/MEM ALU result, 11 EX/MEM load data.
- forwardb  output  3  operand-B select: 000 register file, 001 MEM/WB result, 010 EX/MEM ALU result, 100 EX/MEM load data; 011/101/110/111 never driven.

## Operation
- Armed flag: on a rising clk edge with rst=1, armed <= 0. On a rising edge with rst=0, armed <= 1.
- While armed=0: forwarda=00 and forwardb=000, regardless of the other inputs.
- While armed=1, the outputs are a purely combinational function of the current inputs.
- Register 0 is hardwired zero. A source index of 0 never forwards; it always selects the register file.
- Operand A, first matching rule wins:
  1. xm_memread=1 and xm_rt==dx_rs -> 11.
  2. xm_regwrite=1 and xm_rd==dx_rs -> 10.
  3. mw_regwrite=1 and mw_rd==dx_rs -> 01.
  4. Otherwise -> 00.
- Operand B uses the same priority, compared against dx_rt: load -> 100, EX/MEM ALU -> 010, MEM/WB -> 001, otherwise 000.
- The newest producer (EX/MEM) always beats the older one (MEM/WB).
- The A and B decisions are independent. Both may forward from the same stage at once.
- Any unknown or X input while armed is treated as no-match. The outputs must then resolve to a defined select, never X, so downstream muxes stay clean.

## Timing
- Decode latency is zero: outputs follow input changes combinationally within the same cycle.
- Reset value of every output is 00/000, taking effect from the first rising edge with rst=1.
- The outputs become input-dependent from the first rising edge on which rst=0 is sampled.
- Reset asserted mid-operation: the outputs drop to 00/000 at the next rising edge and stay there until one edge samples rst=0.
- Before the first clock edge, armed is undefined. The implementation initialises it to 0 so the outputs are 00/000 from time zero.

## Test plan
- Reset hold: rst=1 across two edges, all indices=1, xm_regwrite=1 -> forwarda=00, forwardb=000.
- MEM/WB forward: armed, all indices=1, mw_regwrite=1, xm_regwrite=0, xm_memread=0 -> forwarda=01, forwardb=001.
- Load forward: all indices=1, only xm_memread=1 -> forwarda=11, forwardb=100.
- EX/MEM priority: all indices=1, xm_regwrite=1 and mw_regwrite=1 -> forwarda=10, forwardb=010. Then xm_rd=2 with the same enables -> forwarda=01, forwardb=001.
- Independent operands and R0: dx_rs=3, dx_rt=0, xm_rd=3, mw_rd=0, xm_regwrite=1, mw_regwrite=1 -> forwarda=10, forwardb=000.
- Mid-run reset: while forwarding 10/010, assert rst for one edge -> outputs 00/000 after that edge. Deassert -> outputs return to 10/010 after the next edge.
